store_queue: RTL
================

# store_queue

Circular store queue backing the load unit's store-to-load forwarding lookup. Holds in-flight stores from dispatch until in-order retirement. Answers each load lookup in the same cycle with a stall flag, a forwarded byte mask and byte-lane data, computed from stores older than the load's recorded tail position. Drains retired stores to the data-cache write port one cycle after retirement.

## Interface
- `LSQ`, default 3: index width; depth `2**LSQ`; usable capacity `2**LSQ - 1` entries.
- `XLEN`, default 32: address/data width; 4 byte lanes.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `alloc_req` in 1: dispatch requests one store entry.
- `alloc_ok` out 1: entry granted this cycle (`alloc_req && !full`).
- `full` out 1: `count == 2**LSQ - 1`.
- `tail` out LSQ: next index to allocate; dispatch copies it into every store (its entry) and every load (its `tail_pos`).
- `ex_valid` in 1: store FU delivers a resolved store.
- `ex_idx` in LSQ: entry being resolved.
- `ex_addr` in XLEN: store byte address.
- `ex_data` in XLEN: store data already placed in its byte lanes.
- `ex_usebytes` in 4: lanes written.
- `retire_valid` in 1: pop head; head must be resolved.
- `squash` in 1: drop every unretired entry.
- `lookup_addr` in XLEN: load word address, bits [1:0] zero.
- `lookup_tail` in LSQ: load's recorded tail position.
- `lookup_stall` out 1: an older store is unresolved.
- `lookup_usebytes` out 4: lanes supplied by older stores.
- `lookup_data` out XLEN: forwarded lanes; unsupplied lanes zero.
- `mem_wr_en` out 1: registered cache write strobe.
- `mem_addr` out XLEN: word-aligned write address.
- `mem_data` out XLEN: write data.
- `mem_usebytes` out 4: write byte enables.

## Operation
- Per entry: `valid`, `resolved`, `addr`, `data`, `usebytes`. Pointers `head`, `tail`; `count` 0..`2**LSQ-1`. All pointer arithmetic is modulo `2**LSQ`.
- Allocate: when `alloc_req && !full`, mark `tail` valid and unresolved, then increment `tail`. Requests while full are ignored; no same-cycle bypass from a retire.
- Resolve: on `ex_valid`, write `addr`, `data`, `usebytes` into `ex_idx` and set `resolved`. A write to an invalid entry is a protocol error; the bench asserts on it.
- Retire: on `retire_valid`, copy the head entry into the `mem_*` registers with `mem_wr_en=1`, clear it, and increment `head`. Retiring an unresolved or empty head is a protocol error.
- Net count: `count` changes by `+alloc_ok - retire_valid`.
- Squash: the retire of the same cycle executes first. Then all other valid entries are cleared, `tail := head` (post-retire) and `count := 0`. Any `alloc_req` in that cycle is denied and `alloc_ok=0`.
- Lookup (combinational from registered state):
  - The older set is indices `head .. lookup_tail-1` (modulo). It is empty when `lookup_tail == head`.
  - `lookup_stall=1` if any older entry is unresolved.
  - Otherwise, for each lane, search youngest to oldest. The first older entry whose `addr[XLEN-1:2]` matches `lookup_addr[XLEN-1:2]` and whose `usebytes` lane bit is set supplies that lane.
  - When `lookup_stall=1`, `lookup_usebytes` and `lookup_data` are 0.
  - `ex_valid` and `alloc` in the same cycle are not visible to lookup until the next cycle.

## Timing
- Reset (async assert): `head=tail=0`, `count=0`, all entries invalid, `full=0`, `mem_wr_en=0`, `mem_addr/data/usebytes=0`.
  - With `lookup_tail=0`, the lookup outputs read `stall=0`, `usebytes=0`, `data=0`.
  - Reset mid-operation discards all entries, including the pending `mem_*` write.
- `alloc_ok`, `full`, `tail`: reflect current state; `alloc_ok` is combinational on `alloc_req`.
- Lookup: zero-cycle latency; the load unit samples it in the same cycle it presents the address.
- `mem_*`: valid exactly one cycle after `retire_valid`. `mem_wr_en` is a one-cycle pulse per retired store; back-to-back retires give back-to-back pulses.
- Wrap: the older-set range and pointer increments wrap from index `2**LSQ-1` to 0 without gap.

## Test plan
- Reset, then lookup with `lookup_tail=0`, `lookup_addr=0x100` -> `stall=0`, `usebytes=0000`, `data=0`, `mem_wr_en=0`, `tail=0`.
- Allocate 2 stores (idx 0,1); resolve idx0 only (`addr 0x100`, `data 0x000000AA`, `usebytes 0001`); lookup `tail_pos=2`, `addr 0x100` -> `stall=1`. Then resolve idx1 (`addr 0x100`, `data 0xBBBB0000`, `usebytes 1100`) -> `stall=0`, `usebytes=1101`, `data=0xBBBB00AA`.
- Youngest wins: idx0 `0x11111111/1111`, idx1 `0x00002200/0010`, both at `0x200`; lookup `tail_pos=2` -> `usebytes=1111`, `data=0x11112211`. Lookup `tail_pos=1` -> `data=0x11111111`.
- Full and wrap:
  - Allocate 7 entries with LSQ=3 -> `full=1`; an 8th request gives `alloc_ok=0`.
  - Retire 3 -> `mem_wr_en` pulses on 3 consecutive cycles with entries 0..2 data.
  - Allocate 3 more -> `tail` wraps through 7 to 2.
  - A lookup spanning indices 5,6,7,0 forwards correctly.
- Squash with `retire_valid` and `alloc_req` in the same cycle, 4 entries valid:
  - Head retires and `mem_wr_en` pulses next cycle.
  - `count=0`, `tail=head=1`, `alloc_ok=0`.
  - A following lookup with `tail_pos=1` gives no stall.

Source files
------------

// File: rtl/store_queue.sv
// Circular store queue: tracks in-flight stores from dispatch to retirement,
// answers same-cycle store-to-load forwarding lookups and drains retired stores.
module store_queue #(
    parameter int LSQ  = 3,
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            alloc_req,
    output logic            alloc_ok,
    output logic            full,
    output logic [LSQ-1:0]  tail,
    input  logic            ex_valid,
    input  logic [LSQ-1:0]  ex_idx,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_data,
    input  logic [3:0]      ex_usebytes,
    input  logic            retire_valid,
    input  logic            squash,
    input  logic [XLEN-1:0] lookup_addr,
    input  logic [LSQ-1:0]  lookup_tail,
    output logic            lookup_stall,
    output logic [3:0]      lookup_usebytes,
    output logic [XLEN-1:0] lookup_data,
    output logic            mem_wr_en,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_data,
    output logic [3:0]      mem_usebytes
);
    localparam int DEPTH = 2**LSQ;

    logic [DEPTH-1:0] e_valid;
    logic [DEPTH-1:0] e_resolved;
    logic [XLEN-3:0]  e_word [DEPTH];
    logic [XLEN-1:0]  e_data [DEPTH];
    logic [3:0]       e_ub   [DEPTH];

    logic [LSQ-1:0] head;
    logic [LSQ-1:0] count;
    logic [LSQ-1:0] head_inc;
    logic [LSQ-1:0] older_n;
    logic [LSQ-1:0] idx;
    logic           unused_addr_lsbs;

    assign unused_addr_lsbs = ^{lookup_addr[1:0], ex_addr[1:0]};
    assign head_inc = head + LSQ'(1);
    assign full     = (count == '1);
    assign alloc_ok = alloc_req && !full && !squash;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            e_valid      <= '0;
            e_resolved   <= '0;
            mem_wr_en    <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            mem_usebytes <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                e_word[i] <= '0;
                e_data[i] <= '0;
                e_ub[i]   <= '0;
            end
        end else begin
            mem_wr_en <= retire_valid;
            if (ex_valid) begin
                e_word[ex_idx]     <= ex_addr[XLEN-1:2];
                e_data[ex_idx]     <= ex_data;
                e_ub[ex_idx]       <= ex_usebytes;
                e_resolved[ex_idx] <= 1'b1;
            end
            if (retire_valid) begin
                mem_addr         <= {e_word[head], 2'b00};
                mem_data         <= e_data[head];
                mem_usebytes     <= e_ub[head];
                e_valid[head]    <= 1'b0;
                e_resolved[head] <= 1'b0;
                head             <= head_inc;
            end
            if (alloc_ok) begin
                e_valid[tail]    <= 1'b1;
                e_resolved[tail] <= 1'b0;
                tail             <= tail + LSQ'(1);
            end
            // Squash lands after the same-cycle retire, so tail snaps to the post-retire head.
            if (squash) begin
                e_valid    <= '0;
                e_resolved <= '0;
                tail       <= retire_valid ? head_inc : head;
                count      <= '0;
            end else begin
                count <= count + LSQ'(alloc_ok) - LSQ'(retire_valid);
            end
        end
    end

    // Walk oldest to youngest so later matches overwrite earlier ones per lane.
    always_comb begin
        lookup_stall    = 1'b0;
        lookup_usebytes = '0;
        lookup_data     = '0;
        idx             = '0;
        older_n         = lookup_tail - head;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + LSQ'(k);
            if ((LSQ'(k) < older_n) && e_valid[idx]) begin
                if (!e_resolved[idx]) begin
                    lookup_stall = 1'b1;
                end else if (e_word[idx] == lookup_addr[XLEN-1:2]) begin
                    for (int unsigned j = 0; j < 4; j++) begin
                        if (e_ub[idx][j]) begin
                            lookup_usebytes[j]     = 1'b1;
                            lookup_data[8*j +: 8]  = e_data[idx][8*j +: 8];
                        end
                    end
                end
            end
        end
        if (lookup_stall) begin
            lookup_usebytes = '0;
            lookup_data     = '0;
        end
    end
endmodule
